pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central sequencer for the five-stage MIPS pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. It produces per-stage write enables and synchronous flushes, and selects the next-PC source. It handles load-use stalls, taken-branch/ERET flushes, multi-cycle mult/div stalls, and precise exception/interrupt flushes with EPC capture. It sits beside the hazard-detect logic in the CPU top and drives the stage registers' write-enable and flush inputs directly.

Parameters:
MD_CYCLES, 32, total stall cycles for one mult/div operation (>=1)
CNT_W, 6, mult/div counter width; must hold MD_CYCLES-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt
ex_memread  in  1  instruction in EX is a load
ex_rt  in  5  load destination in EX
ex_md_start  in  1  mult/div instruction in EX
ex_branch_taken  in  1  branch/jump resolved taken in EX
ex_eret  in  1  ERET in EX
mem_exc_req  in  1  synchronous exception flagged in MEM
int_req  in  1  external interrupt request (level)
int_en  in  1  interrupt enable from status register
pcw  out  1  PC write enable
ifidw, idexw, exmemw, memwbw  out  1 each  stage write enables
ifid_flush, idex_flush, exmem_flush  out  1 each  stage synchronous clears (active high)
pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = exception vector, 3 = EPC
epc_we  out  1  capture EPC this cycle
exc_ack  out  1  exception/interrupt accepted
md_busy  out  1  mult/div stall active

Behaviour:
- State register: RUN, MD_BUSY, EXC. Also a counter cnt[CNT_W-1:0] and a one-cycle flag md_done. Outputs are combinational from state, flags and inputs.
- Reset (rst=0 at a clock edge):
  - next state RUN, cnt=0, md_done=0.
  - While rst=0: all write enables 0; all flushes 1; pc_sel=0; epc_we=0; exc_ack=0; md_busy=0.
- Default in RUN: all write enables 1, flushes 0, pc_sel=0.
- Priority within a cycle: exception > mult/div > branch/ERET > load-use.
- Exception take: accepted in RUN or MD_BUSY when mem_exc_req=1, or int_req & int_en.
  - Same cycle: exc_ack=1, epc_we=1, pc_sel=2, pcw=1, ifid_flush=idex_flush=exmem_flush=1, memwbw=1.
  - Next state EXC; cnt cleared; any mult/div in progress is abandoned.
- EXC (exactly 1 cycle): mem_exc_req and int_req are ignored. ifid_flush=idex_flush=1 so vector-fetch slots are clean. pcw=1, pc_sel=0. Next state RUN.
- Mult/div start: in RUN with ex_md_start=1, md_done=0 and no exception.
  - md_busy=1; pcw=ifidw=idexw=0; exmem_flush=1; memwbw=1.
  - If MD_CYCLES>1: cnt<=MD_CYCLES-1, next state MD_BUSY. Otherwise set md_done and stay in RUN.
- MD_BUSY: same outputs as the start cycle. cnt decrements each cycle.
  - When cnt==1: next state RUN and set md_done.
  - Total stalled cycles equal MD_CYCLES, start cycle included.
- md_done: valid for the first RUN cycle after a stall. ex_md_start is ignored that cycle so the held instruction advances without retriggering. Cleared after one cycle.
- Branch/ERET (RUN, no higher-priority event):
  - ex_branch_taken=1: pc_sel=1, ifid_flush=idex_flush=1, pcw=1.
  - ex_eret=1: pc_sel=3, same flushes.
  - If both are set, ERET wins.
- Load-use (RUN, none of the above): triggered when ex_memread=1, ex_rt!=0, and either ex_rt==id_rs or (id_uses_rt=1 and ex_rt==id_rt).
  - Response: pcw=ifidw=0, idex_flush=1 (bubble); other enables 1. Lasts 1 cycle.
- A load-use condition coinciding with a branch is dropped, because the branch flush removes the dependent instruction.
- Reset asserted mid-MD_BUSY or mid-EXC: forces RUN next edge with cnt=0.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> all enables 0, flushes 1, pc_sel=0. Release -> first cycle all enables 1, flushes 0.
- Load-use: ex_memread=1, ex_rt=5, id_rs=5 -> exactly one cycle of pcw=0, ifidw=0, idex_flush=1. With ex_rt=0 -> no stall.
- Mult/div: MD_CYCLES=4, pulse ex_md_start held high -> md_busy=1 for exactly 4 cycles with pcw=0 and exmem_flush=1. Next cycle is normal even though ex_md_start is still 1.
- Exception during MD_BUSY: mem_exc_req=1 in busy cycle 2 -> same cycle exc_ack=1, epc_we=1, pc_sel=2, three flushes. Next cycle EXC, then RUN; md_busy=0.
- Interrupt masking: int_req=1 with int_en=0 -> no ack. int_en=1 -> ack. int_req held during the EXC cycle -> no second ack in that cycle; a second ack occurs in the following RUN cycle.
- Branch vs load-use: ex_branch_taken=1 with a concurrent load-use match -> pc_sel=1, ifid_flush=idex_flush=1, pcw=1, no stall. Branch and ERET together -> pc_sel=3.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central sequencer for the five-stage pipeline registers and the PC.
// Produces per-stage write enables and synchronous flushes, and selects the next-PC source.
// It handles load-use stalls, taken-branch/ERET flushes, multi-cycle mult/div stalls and
// precise exception/interrupt flushes with EPC capture.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-low reset
//   id_rs, id_rt,        source registers of the ID instruction; id_uses_rt is high when rt
//   id_uses_rt           is actually read
//   ex_memread, ex_rt    load in EX and its destination register
//   ex_md_start          mult/div instruction sitting in EX
//   ex_branch_taken      branch/jump resolved taken in EX
//   ex_eret              ERET in EX
//   mem_exc_req          synchronous exception flagged in MEM
//   int_req, int_en      level interrupt request and its enable
//   pcw, ifidw, idexw,   PC and stage-register write enables
//   exmemw, memwbw
//   ifid_flush,          synchronous stage clears, active high
//   idex_flush,
//   exmem_flush
//   pc_sel               0 PC+4, 1 branch target, 2 exception vector, 3 EPC
//   epc_we, exc_ack      EPC capture strobe and exception/interrupt accept
//   md_busy              mult/div stall active
module pipe_hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 32,
  parameter int unsigned CNT_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       ex_md_start,
  input  logic       ex_branch_taken,
  input  logic       ex_eret,
  input  logic       mem_exc_req,
  input  logic       int_req,
  input  logic       int_en,
  output logic       pcw,
  output logic       ifidw,
  output logic       idexw,
  output logic       exmemw,
  output logic       memwbw,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic [1:0] pc_sel,
  output logic       epc_we,
  output logic       exc_ack,
  output logic       md_busy
);

  typedef enum logic [1:0] {StRun, StMdBusy, StExc} state_e;

  localparam logic [1:0] PcSeq  = 2'd0;
  localparam logic [1:0] PcBr   = 2'd1;
  localparam logic [1:0] PcVec  = 2'd2;
  localparam logic [1:0] PcEpc  = 2'd3;

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_done_q, md_done_d;

  logic exc_take;
  logic load_use;
  logic md_start;

  // The EXC cycle deliberately ignores new requests so one event yields one ack.
  assign exc_take = (state_q != StExc) && (mem_exc_req || (int_req && int_en));

  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // md_done lets the held mult/div instruction advance without retriggering.
  assign md_start = ex_md_start && !md_done_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      md_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_done_q <= md_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    md_done_d   = 1'b0;
    pcw         = 1'b1;
    ifidw       = 1'b1;
    idexw       = 1'b1;
    exmemw      = 1'b1;
    memwbw      = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pc_sel      = PcSeq;
    epc_we      = 1'b0;
    exc_ack     = 1'b0;
    md_busy     = 1'b0;

    if (!rst) begin
      pcw         = 1'b0;
      ifidw       = 1'b0;
      idexw       = 1'b0;
      exmemw      = 1'b0;
      memwbw      = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (exc_take) begin
      // Faulting instruction in MEM is retired into WB; everything younger is cleared.
      exc_ack     = 1'b1;
      epc_we      = 1'b1;
      pc_sel      = PcVec;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_d     = StExc;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        StExc: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_d    = StRun;
        end
        StMdBusy: begin
          md_busy     = 1'b1;
          pcw         = 1'b0;
          ifidw       = 1'b0;
          idexw       = 1'b0;
          exmem_flush = 1'b1;
          cnt_d       = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_d   = StRun;
            md_done_d = 1'b1;
          end
        end
        default: begin
          if (md_start) begin
            md_busy     = 1'b1;
            pcw         = 1'b0;
            ifidw       = 1'b0;
            idexw       = 1'b0;
            exmem_flush = 1'b1;
            if (MD_CYCLES > 1) begin
              cnt_d   = CntLoad;
              state_d = StMdBusy;
            end else begin
              md_done_d = 1'b1;
            end
          end else if (ex_eret || ex_branch_taken) begin
            // A concurrent load-use is dropped: the flush removes the dependent instruction.
            pc_sel     = ex_eret ? PcEpc : PcBr;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pcw        = 1'b0;
            ifidw      = 1'b0;
            idex_flush = 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, ex_md_start, ex_branch_taken, ex_eret;
  logic       mem_exc_req, int_req, int_en;
  logic       pcw, ifidw, idexw, exmemw, memwbw;
  logic       ifid_flush, idex_flush, exmem_flush;
  logic [1:0] pc_sel;
  logic       epc_we, exc_ack, md_busy;

  int checks = 0;
  int errors = 0;

  // {pcw,ifidw,idexw,exmemw,memwbw, ifid_fl,idex_fl,exmem_fl, pc_sel, epc_we,exc_ack,md_busy}
  logic [12:0] obs;
  assign obs = {pcw, ifidw, idexw, exmemw, memwbw, ifid_flush, idex_flush, exmem_flush,
                pc_sel, epc_we, exc_ack, md_busy};

  localparam logic [12:0] ExpRst  = 13'b00000_111_00_000;
  localparam logic [12:0] ExpNorm = 13'b11111_000_00_000;
  localparam logic [12:0] ExpLu   = 13'b00111_010_00_000;
  localparam logic [12:0] ExpMd   = 13'b00011_001_00_001;
  localparam logic [12:0] ExpTake = 13'b11111_111_10_110;
  localparam logic [12:0] ExpExc  = 13'b11111_110_00_000;
  localparam logic [12:0] ExpBr   = 13'b11111_110_01_000;
  localparam logic [12:0] ExpEret = 13'b11111_110_11_000;

  pipe_hazard_ctrl #(
    .MD_CYCLES(4),
    .CNT_W    (6)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rt     (id_uses_rt),
    .ex_memread     (ex_memread),
    .ex_rt          (ex_rt),
    .ex_md_start    (ex_md_start),
    .ex_branch_taken(ex_branch_taken),
    .ex_eret        (ex_eret),
    .mem_exc_req    (mem_exc_req),
    .int_req        (int_req),
    .int_en         (int_en),
    .pcw            (pcw),
    .ifidw          (ifidw),
    .idexw          (idexw),
    .exmemw         (exmemw),
    .memwbw         (memwbw),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .exmem_flush    (exmem_flush),
    .pc_sel         (pc_sel),
    .epc_we         (epc_we),
    .exc_ack        (exc_ack),
    .md_busy        (md_busy)
  );

  always #5 clk = ~clk;

  // Sample mid-cycle, then advance to just after the next rising edge.
  task automatic chk(input string tag, input logic [12:0] exp);
    @(negedge clk);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_memread = 1'b0; ex_rt = 5'd0; ex_md_start = 1'b0;
    ex_branch_taken = 1'b0; ex_eret = 1'b0;
    mem_exc_req = 1'b0; int_req = 1'b0; int_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();

    // Reset held for three cycles.
    chk("rst0", ExpRst);
    chk("rst1", ExpRst);
    chk("rst2", ExpRst);
    rst = 1'b1;
    chk("run_after_rst", ExpNorm);

    // Load-use on rs.
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    chk("lu_rs", ExpLu);
    clear_inputs();
    chk("lu_done", ExpNorm);
    // Load-use on rt, only when rt is read.
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b1;
    chk("lu_rt", ExpLu);
    id_uses_rt = 1'b0;
    chk("lu_rt_unused", ExpNorm);
    // $zero never stalls.
    ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    chk("lu_r0", ExpNorm);
    clear_inputs();

    // Mult/div held high: four stall cycles, then one normal cycle.
    ex_md_start = 1'b1;
    chk("md_c1", ExpMd);
    chk("md_c2", ExpMd);
    chk("md_c3", ExpMd);
    chk("md_c4", ExpMd);
    chk("md_done", ExpNorm);
    // Still high -> new operation starts; exception in busy cycle 2 preempts it.
    chk("md2_c1", ExpMd);
    mem_exc_req = 1'b1;
    chk("exc_in_md", ExpTake);
    clear_inputs();
    chk("exc_state", ExpExc);
    chk("exc_back_run", ExpNorm);

    // Interrupt masking and one ack per EXC cycle.
    int_req = 1'b1;
    chk("int_masked", ExpNorm);
    int_en = 1'b1;
    chk("int_take1", ExpTake);
    chk("int_ignored_exc", ExpExc);
    chk("int_take2", ExpTake);
    clear_inputs();
    chk("int_exc2", ExpExc);
    chk("int_run", ExpNorm);

    // Branch beats load-use; ERET beats branch.
    ex_branch_taken = 1'b1; ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    chk("br_over_lu", ExpBr);
    ex_eret = 1'b1;
    chk("eret_over_br", ExpEret);
    clear_inputs();
    ex_eret = 1'b1;
    chk("eret_only", ExpEret);
    // Exception beats branch; branch ignored in EXC.
    ex_eret = 1'b0; ex_branch_taken = 1'b1; mem_exc_req = 1'b1;
    chk("exc_over_br", ExpTake);
    chk("exc_state_br", ExpExc);
    clear_inputs();
    // Exception beats mult/div start in RUN.
    ex_md_start = 1'b1; mem_exc_req = 1'b1;
    chk("exc_over_md", ExpTake);
    clear_inputs();
    chk("exc_state_md", ExpExc);

    // Reset in the middle of a mult/div stall.
    ex_md_start = 1'b1;
    chk("md3_c1", ExpMd);
    chk("md3_c2", ExpMd);
    rst = 1'b0;
    chk("rst_mid_md", ExpRst);
    rst = 1'b1;
    ex_md_start = 1'b0;
    chk("run_after_md_rst", ExpNorm);
    // md_done must have been cleared: a fresh start stalls immediately.
    ex_md_start = 1'b1;
    chk("md_restart", ExpMd);
    ex_md_start = 1'b0;
    chk("md_restart_c2", ExpMd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
